egg_count_ctrl: RTL and testbench

//   Upstream stage of the dot-matrix egg display. Debounces two raw push buttons (add/take)
//   and maintains a saturating egg count 0..MAX_EGGS, driven out as num[2:0] for the

---
 rtl/egg_count_ctrl_if.sv | 28 ++
 rtl/egg_count_ctrl.sv | 134 +++++++++++++
 tb/tb_egg_count_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/egg_count_ctrl_if.sv
// Button inputs and count/status outputs of the egg count controller.
// The master side drives the raw buttons; the slave side is the controller.
interface egg_count_ctrl_if;
  logic       btn_add;
  logic       btn_take;
  logic [2:0] num;
  logic       full;
  logic       empty;
  logic       err;

  modport master (
    output btn_add,
    output btn_take,
    input  num,
    input  full,
    input  empty,
    input  err
  );

  modport slave (
    input  btn_add,
    input  btn_take,
    output num,
    output full,
    output empty,
    output err
  );
endinterface

// File: rtl/egg_count_ctrl.sv
// Debounces the add/take buttons and keeps a saturating egg count for the display stage.
// Optional feature macro: EGG_AUTO_REFILL_EN refills an empty tray after REFILL_CYC idle cycles.
module egg_count_ctrl #(
  parameter int unsigned MAX_EGGS   = 4,
  parameter int unsigned INIT_EGGS  = 4,
  parameter int unsigned DB_CYC     = 20,
  parameter int unsigned REFILL_CYC = 3000
) (
  input logic             clk,
  input logic             rst,
  egg_count_ctrl_if.slave egg
);

  localparam int unsigned   CNT_W    = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYC - 1);
  localparam logic [2:0]    NUM_MAX  = 3'(MAX_EGGS);
  localparam logic [2:0]    NUM_INIT = 3'(INIT_EGGS);
  localparam int unsigned   B_ADD    = 0;
  localparam int unsigned   B_TAKE   = 1;

  logic [1:0]       w_raw;
  logic [1:0]       r_meta;
  logic [1:0]       r_sync;
  logic [1:0]       r_acc;
  logic [1:0]       r_acc_d;
  logic [1:0]       r_ev;
  logic [CNT_W-1:0] r_cnt [2];

  logic [2:0]       r_num;
  logic             r_full;
  logic             r_empty;
  logic             r_err;

  logic             w_add_ev;
  logic             w_take_ev;
  logic             w_refill;
  logic [2:0]       w_num_nxt;
  logic             w_err_nxt;

  assign w_raw = {egg.btn_take, egg.btn_add};

  // Two-flop synchroniser, per-button debounce, and rising-edge detect of the accepted level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta  <= '0;
      r_sync  <= '0;
      r_acc   <= '0;
      r_acc_d <= '0;
      r_ev    <= '0;
      // NOTE: the counter array is plain flops, not a RAM, so every element is reset explicitly.
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge values of the others.
      r_meta  <= w_raw;
      r_sync  <= r_meta;
      r_acc_d <= r_acc;
      r_ev    <= r_acc & ~r_acc_d;
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] == r_acc[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_acc[i] <= r_sync[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign w_add_ev  = r_ev[B_ADD];
  assign w_take_ev = r_ev[B_TAKE];

`ifdef EGG_AUTO_REFILL_EN
  localparam int unsigned    RF_W    = (REFILL_CYC > 1) ? $clog2(REFILL_CYC) : 1;
  localparam logic [RF_W-1:0] RF_LAST = RF_W'(REFILL_CYC - 1);

  logic [RF_W-1:0] r_timer;

  assign w_refill = (r_num == 3'd0) && !w_add_ev && !w_take_ev && (r_timer == RF_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= '0;
    end else if (w_add_ev || w_take_ev || (r_num != 3'd0) || (r_timer == RF_LAST)) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + RF_W'(1);
    end
  end
`else
  assign w_refill = 1'b0;

  // REFILL_CYC only sizes the refill timer, which this build leaves out.
  if (REFILL_CYC == 0) begin : g_refill_unused
  end
`endif

  // Simultaneous add and take cancel; refusals at the limits raise err for one cycle.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    w_num_nxt = r_num;
    w_err_nxt = 1'b0;
    if (w_add_ev && !w_take_ev) begin
      if (r_num < NUM_MAX) w_num_nxt = r_num + 3'd1;
      else                 w_err_nxt = 1'b1;
    end else if (w_take_ev && !w_add_ev) begin
      if (r_num != 3'd0) w_num_nxt = r_num - 3'd1;
      else               w_err_nxt = 1'b1;
    end else if (w_refill) begin
      w_num_nxt = NUM_MAX;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_num   <= NUM_INIT;
      r_full  <= (NUM_INIT == NUM_MAX);
      r_empty <= (NUM_INIT == 3'd0);
      r_err   <= 1'b0;
    end else begin
      r_num   <= w_num_nxt;
      r_full  <= (w_num_nxt == NUM_MAX);
      r_empty <= (w_num_nxt == 3'd0);
      r_err   <= w_err_nxt;
    end
  end

  assign egg.num   = r_num;
  assign egg.full  = r_full;
  assign egg.empty = r_empty;
  assign egg.err   = r_err;

endmodule

// File: tb/tb_egg_count_ctrl.sv
// Randomised and directed bench for egg_count_ctrl against a cycle-level reference model.
// Honours EGG_AUTO_REFILL_EN the same way as the design.
module tb_egg_count_ctrl;

  localparam int MAX_EGGS   = 4;
  localparam int INIT_EGGS  = 4;
  localparam int DB_CYC     = 20;
  localparam int REFILL_CYC = 100;

  logic clk = 1'b0;
  logic rst;

  egg_count_ctrl_if egg_if ();

  egg_count_ctrl #(
    .MAX_EGGS  (MAX_EGGS),
    .INIT_EGGS (INIT_EGGS),
    .DB_CYC    (DB_CYC),
    .REFILL_CYC(REFILL_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .egg(egg_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: button level seen by the logic is the raw level two edges earlier;
  // a level is accepted after DB_CYC consecutive differing samples; a press lands 2 edges later.
  int m_num;
  int m_timer;
  bit m_err;
  bit hist1 [2];
  bit hist2 [2];
  bit m_acc [2];
  int m_run [2];
  int cyc;
  int due_add[$];
  int due_take[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_num   = INIT_EGGS;
    m_timer = 0;
    m_err   = 1'b0;
    for (int b = 0; b < 2; b++) begin
      hist1[b] = 1'b0;
      hist2[b] = 1'b0;
      m_acc[b] = 1'b0;
      m_run[b] = 0;
    end
    due_add.delete();
    due_take.delete();
    cyc = 0;
  endtask

  task automatic model_step(input bit a, input bit t);
    bit s;
    bit raw [2];
    bit add_now;
    bit take_now;
    bit refused;
    int old;
    raw[0] = a;
    raw[1] = t;
    for (int b = 0; b < 2; b++) begin
      s        = hist2[b];
      hist2[b] = hist1[b];
      hist1[b] = raw[b];
      if (s != m_acc[b]) begin
        m_run[b]++;
        if (m_run[b] == DB_CYC) begin
          m_acc[b] = s;
          m_run[b] = 0;
          if (s) begin
            if (b == 0) due_add.push_back(cyc + 2);
            else        due_take.push_back(cyc + 2);
          end
        end
      end else begin
        m_run[b] = 0;
      end
    end
    add_now  = (due_add.size() > 0) && (due_add[0] == cyc);
    take_now = (due_take.size() > 0) && (due_take[0] == cyc);
    if (add_now)  void'(due_add.pop_front());
    if (take_now) void'(due_take.pop_front());
    old     = m_num;
    refused = 1'b0;
    if (add_now && !take_now) begin
      if (m_num < MAX_EGGS) m_num++;
      else                  refused = 1'b1;
    end else if (take_now && !add_now) begin
      if (m_num > 0) m_num--;
      else           refused = 1'b1;
    end
`ifdef EGG_AUTO_REFILL_EN
    if (!(add_now || take_now) && old == 0) begin
      if (m_timer == REFILL_CYC - 1) begin
        m_num   = MAX_EGGS;
        m_timer = 0;
      end else begin
        m_timer++;
      end
    end else begin
      m_timer = 0;
    end
`else
    if (old < 0) m_timer = 0;
`endif
    m_err = refused;
    cyc++;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".num"},   {29'b0, egg_if.num},   32'(m_num));
    check({tag, ".full"},  {31'b0, egg_if.full},  {31'b0, (m_num == MAX_EGGS)});
    check({tag, ".empty"}, {31'b0, egg_if.empty}, {31'b0, (m_num == 0)});
    check({tag, ".err"},   {31'b0, egg_if.err},   {31'b0, m_err});
  endtask

  // One clock: drive raw buttons after a falling edge, step model at the rising edge, compare at the next falling edge.
  task automatic tick(input bit a, input bit t, input string tag);
    egg_if.btn_add  = a;
    egg_if.btn_take = t;
    @(posedge clk);
    model_step(a, t);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic hold(input bit a, input bit t, input int n, input string tag);
    for (int i = 0; i < n; i++) tick(a, t, tag);
  endtask

  task automatic do_reset_now();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst.num",   {29'b0, egg_if.num},   32'(INIT_EGGS));
    check("rst.full",  {31'b0, egg_if.full},  {31'b0, (INIT_EGGS == MAX_EGGS)});
    check("rst.empty", {31'b0, egg_if.empty}, {31'b0, (INIT_EGGS == 0)});
    check("rst.err",   {31'b0, egg_if.err},   32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int errs;
  int run_a, run_t;
  bit lvl_a, lvl_t;

  initial begin
    egg_if.btn_add  = 1'b0;
    egg_if.btn_take = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    do_reset_now();

    // Add held at full: one refused event only.
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1'b1, 1'b0, "add_at_full");
      errs += int'(egg_if.err);
    end
    check("add_at_full.err_pulses", 32'(errs), 32'd1);
    check("add_at_full.num", {29'b0, egg_if.num}, 32'(MAX_EGGS));
    hold(1'b0, 1'b0, 50, "release");

    // Four clean takes count down to empty; a fifth is refused.
    for (int k = 0; k < 4; k++) begin
      hold(1'b0, 1'b1, 50, "take");
      hold(1'b0, 1'b0, 50, "take_gap");
      check("take_seq.num", {29'b0, egg_if.num}, 32'(MAX_EGGS - 1 - k));
    end
    check("take_seq.empty", {31'b0, egg_if.empty}, 32'd1);
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1'b0, (i < 50), "take_at_empty");
      errs += int'(egg_if.err);
    end
    check("take_at_empty.err_pulses", 32'(errs), 32'd1);
    check("take_at_empty.num", {29'b0, egg_if.num}, 32'd0);

    // Idle while empty.
    hold(1'b0, 1'b0, 200, "idle_empty");
`ifdef EGG_AUTO_REFILL_EN
    check("idle_empty.num", {29'b0, egg_if.num}, 32'(MAX_EGGS));
`else
    check("idle_empty.num", {29'b0, egg_if.num}, 32'd0);
`endif

    // Two adds, then take glitches shorter than the debounce window.
    for (int k = 0; k < 2; k++) begin
      hold(1'b1, 1'b0, 40, "add");
      hold(1'b0, 1'b0, 40, "add_gap");
    end
    for (int i = 0; i < 200; i++) tick(1'b0, ((i % 20) < 10), "glitch");
    hold(1'b0, 1'b0, 30, "glitch_tail");

    // Both buttons on the same edge cancel.
    hold(1'b1, 1'b1, 50, "both");
    hold(1'b0, 1'b0, 40, "both_gap");

    // Random level runs, from sub-debounce glitches to long holds.
    run_a = 0;
    run_t = 0;
    lvl_a = 1'b0;
    lvl_t = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (run_a == 0) begin
        lvl_a = 1'($urandom_range(0, 1));
        run_a = int'($urandom_range(1, 45));
      end
      if (run_t == 0) begin
        lvl_t = 1'($urandom_range(0, 1));
        run_t = int'($urandom_range(1, 45));
      end
      if ($urandom_range(0, 63) == 0) begin
        lvl_t = lvl_a;
        run_t = run_a;
      end
      tick(lvl_a, lvl_t, "random");
      run_a--;
      run_t--;
    end

    // Reset while a press is pending, then keep the button held through release of reset.
    hold(1'b0, 1'b1, 40, "pre_rst_take");
    hold(1'b0, 1'b0, 30, "pre_rst_gap");
    hold(1'b0, 1'b1, 10, "mid_press");
    do_reset_now();
    hold(1'b0, 1'b1, 60, "held_after_rst");
    check("held_after_rst.num", {29'b0, egg_if.num}, 32'(INIT_EGGS - 1));
    hold(1'b0, 1'b0, 40, "tail");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
